// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes, main-decoder op classes,
// R-type funct values and the ID/EX operand-select encoding.
package cpu_pkg;

    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned IMM_W   = 16;

    // ALU control codes
    localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1001;
    localparam logic [CTRL_W-1:0] ALU_LUI  = 4'b1011;

    // Main-decoder op classes
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_BR    = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTIU = 3'b101;

    // R-type funct values
    localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FUNCT_SUBU = 6'h23;
    localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'h2A;
    localparam logic [FUNCT_W-1:0] FUNCT_SLTU = 6'h2B;
    localparam logic [FUNCT_W-1:0] FUNCT_SRA  = 6'h03;
    localparam logic [FUNCT_W-1:0] FUNCT_SRAV = 6'h07;

    // Operand routing chosen at load; zero encoding is the plain rs/rt pair
    typedef enum logic [1:0] {
        OPSEL_REG   = 2'd0,
        OPSEL_IMM   = 2'd1,
        OPSEL_SHAMT = 2'd2,
        OPSEL_SHVAR = 2'd3
    } op_sel_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ALU control decoder: maps main-decoder op class and funct to the 4-bit
// ALU control code and flags combinations that have no defined operation.
module alu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               legal
);

    // Table lookup; unknown combinations fall back to AND and are marked illegal
    always_comb begin
        ctrl  = ALU_AND;
        legal = 1'b1;
        case (alu_op)
            ALUOP_ADD:   ctrl = ALU_ADD;
            ALUOP_BR:    ctrl = ALU_SUB;
            ALUOP_ORI:   ctrl = ALU_OR;
            ALUOP_LUI:   ctrl = ALU_LUI;
            ALUOP_SLTIU: ctrl = ALU_SLTU;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADDU: ctrl = ALU_ADD;
                    FUNCT_SUBU: ctrl = ALU_SUB;
                    FUNCT_AND:  ctrl = ALU_AND;
                    FUNCT_OR:   ctrl = ALU_OR;
                    FUNCT_SLT:  ctrl = ALU_SLT;
                    FUNCT_SLTU: ctrl = ALU_SLTU;
                    FUNCT_SRA:  ctrl = ALU_SRA;
                    FUNCT_SRAV: ctrl = ALU_SRA;
                    default: begin
                        ctrl  = ALU_AND;
                        legal = 1'b0;
                    end
                endcase
            end
            default: begin
                ctrl  = ALU_AND;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage feeding the 32-bit ALU: registers decoded fields,
// resolves RAW hazards from EX/MEM and MEM/WB, and selects ALU operands.
// Build option: define ID_EX_FORWARD_EN to enable the forwarding muxes;
// without it operands come only from the registered register-file data.
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [DW-1:0]      rs_data_i,
    input  logic [DW-1:0]      rt_data_i,
    input  logic [RW-1:0]      rs_i,
    input  logic [RW-1:0]      rt_i,
    input  logic [RW-1:0]      rd_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [IMM_W-1:0]   imm16_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [ALUOP_W-1:0] alu_op_i,
    input  logic               alu_src_i,
    input  logic               zext_i,
    input  logic               reg_dst_i,
    input  logic               reg_write_i,
    input  logic               exmem_wen_i,
    input  logic [RW-1:0]      exmem_rd_i,
    input  logic [DW-1:0]      exmem_data_i,
    input  logic               memwb_wen_i,
    input  logic [RW-1:0]      memwb_rd_i,
    input  logic [DW-1:0]      memwb_data_i,
    output logic [DW-1:0]      alu_src1_o,
    output logic [DW-1:0]      alu_src2_o,
    output logic [CTRL_W-1:0]  alu_ctrl_o,
    output logic [DW-1:0]      rt_fwd_o,
    output logic [RW-1:0]      wr_reg_o,
    output logic               reg_write_o,
    output logic               valid_o
);

    localparam int unsigned IMM_PAD   = DW - IMM_W;
    localparam int unsigned SHAMT_PAD = DW - SHAMT_W;

    // Stage registers
    logic               valid_q;
    logic               reg_write_q;
    logic [DW-1:0]      rs_data_q;
    logic [DW-1:0]      rt_data_q;
    logic [RW-1:0]      rs_q;
    logic [RW-1:0]      rt_q;
    logic [RW-1:0]      rd_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [IMM_W-1:0]   imm16_q;
    logic               zext_q;
    logic               reg_dst_q;
    logic [CTRL_W-1:0]  ctrl_q;
    op_sel_e            op_sel_q;

    logic [CTRL_W-1:0]  dec_ctrl;
    logic               dec_legal;
    op_sel_e            op_sel_d;
    logic [DW-1:0]      fwd_rs;
    logic [DW-1:0]      fwd_rt;
    logic [DW-1:0]      imm_ext;

    alu_ctrl_decode u_alu_ctrl_decode (
        .alu_op (alu_op_i),
        .funct  (funct_i),
        .ctrl   (dec_ctrl),
        .legal  (dec_legal)
    );

    // Operand routing for the incoming instruction; shifts take precedence over alu_src
    always_comb begin
        op_sel_d = OPSEL_REG;
        if (alu_op_i == ALUOP_RTYPE && funct_i == FUNCT_SRA) begin
            op_sel_d = OPSEL_SHAMT;
        end else if (alu_op_i == ALUOP_RTYPE && funct_i == FUNCT_SRAV) begin
            op_sel_d = OPSEL_SHVAR;
        end else if (alu_src_i) begin
            op_sel_d = OPSEL_IMM;
        end
    end

    // Stage register update: reset and flush both load a bubble, stall holds
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            shamt_q     <= '0;
            imm16_q     <= '0;
            zext_q      <= 1'b0;
            reg_dst_q   <= 1'b0;
            ctrl_q      <= ALU_AND;
            op_sel_q    <= OPSEL_REG;
        end else if (!stall_i) begin
            valid_q     <= valid_i;
            reg_write_q <= reg_write_i & valid_i & dec_legal;
            rs_data_q   <= rs_data_i;
            rt_data_q   <= rt_data_i;
            rs_q        <= rs_i;
            rt_q        <= rt_i;
            rd_q        <= rd_i;
            shamt_q     <= shamt_i;
            imm16_q     <= imm16_i;
            zext_q      <= zext_i;
            reg_dst_q   <= reg_dst_i;
            ctrl_q      <= dec_ctrl;
            op_sel_q    <= op_sel_d;
        end
    end

`ifdef ID_EX_FORWARD_EN
    // RAW bypass: EX/MEM beats MEM/WB, register 0 is never bypassed
    always_comb begin
        fwd_rs = rs_data_q;
        fwd_rt = rt_data_q;
        if (exmem_wen_i && exmem_rd_i == rs_q && rs_q != '0) begin
            fwd_rs = exmem_data_i;
        end else if (memwb_wen_i && memwb_rd_i == rs_q && rs_q != '0) begin
            fwd_rs = memwb_data_i;
        end
        if (exmem_wen_i && exmem_rd_i == rt_q && rt_q != '0) begin
            fwd_rt = exmem_data_i;
        end else if (memwb_wen_i && memwb_rd_i == rt_q && rt_q != '0) begin
            fwd_rt = memwb_data_i;
        end
    end
`else
    // No bypass: hazards are covered by stalling upstream
    always_comb begin
        fwd_rs = rs_data_q;
        fwd_rt = rt_data_q;
    end

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exmem_wen_i, exmem_rd_i, exmem_data_i,
                                 memwb_wen_i, memwb_rd_i, memwb_data_i};
`endif

    // Immediate extension
    always_comb begin
        if (zext_q) begin
            imm_ext = {{IMM_PAD{1'b0}}, imm16_q};
        end else begin
            imm_ext = {{IMM_PAD{imm16_q[IMM_W-1]}}, imm16_q};
        end
    end

    // ALU operand select
    always_comb begin
        alu_src1_o = fwd_rs;
        alu_src2_o = fwd_rt;
        case (op_sel_q)
            OPSEL_SHAMT: begin
                alu_src1_o = fwd_rt;
                alu_src2_o = {{SHAMT_PAD{1'b0}}, shamt_q};
            end
            OPSEL_SHVAR: begin
                alu_src1_o = fwd_rt;
                alu_src2_o = fwd_rs;
            end
            OPSEL_IMM: begin
                alu_src1_o = fwd_rs;
                alu_src2_o = imm_ext;
            end
            default: begin
                alu_src1_o = fwd_rs;
                alu_src2_o = fwd_rt;
            end
        endcase
    end

    assign alu_ctrl_o  = ctrl_q;
    assign rt_fwd_o    = fwd_rt;
    assign wr_reg_o    = reg_dst_q ? rd_q : rt_q;
    assign reg_write_o = reg_write_q;
    assign valid_o     = valid_q;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the 32-bit ALU.
- Registers decoded operands, immediate, shamt and destination register, and computes the 4-bit ALU control code from alu_op/funct.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, then drives the ALU's src1/src2/ctrl inputs.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- stall_i  input  1  hold all stage registers.
- flush_i  input  1  load bubble.
- valid_i  input  1  incoming instruction valid.
- rs_data_i  input  DW  register-file read data, rs.
- rt_data_i  input  DW  register-file read data, rt.
- rs_i  input  RW  rs index.
- rt_i  input  RW  rt index.
- rd_i  input  RW  rd index.
- shamt_i  input  5  shift amount.
- imm16_i  input  16  instruction immediate.
- funct_i  input  6  R-type funct.
- alu_op_i  input  3  main-decoder op class.
- alu_src_i  input  1  1 = src2 is immediate.
- zext_i  input  1  1 = zero-extend imm, 0 = sign-extend.
- reg_dst_i  input  1  1 = write rd, 0 = write rt.
- reg_write_i  input  1  instruction writes register file.
- exmem_wen_i  input  1  EX/MEM register-write enable.
- exmem_rd_i  input  RW  EX/MEM destination index.
- exmem_data_i  input  DW  EX/MEM result.
- memwb_wen_i  input  1  MEM/WB register-write enable.
- memwb_rd_i  input  RW  MEM/WB destination index.
- memwb_data_i  input  DW  MEM/WB writeback data.
- alu_src1_o  output  DW  to ALU src1.
- alu_src2_o  output  DW  to ALU src2.
- alu_ctrl_o  output  4  to ALU ctrl.
- rt_fwd_o  output  DW  forwarded rt value (store data).
- wr_reg_o  output  RW  destination register.
- reg_write_o  output  1  gated by valid.
- valid_o  output  1  stage holds a real instruction.

Behaviour:
- Reset (rst_i == 0 at posedge):
  - All stage registers are zero: valid_o = 0, reg_write_o = 0, wr_reg_o = 0.
  - With registered data zero, alu_src1_o and alu_src2_o are 0 and alu_ctrl_o is 4'b0000 (AND).
  - Reset overrides stall and flush.
- Per edge, priority is reset > flush > stall > load.
  - Flush: load a bubble (valid = 0, reg_write = 0, all fields 0).
  - Stall: all registers hold.
  - Load: capture inputs; the stored reg_write is reg_write_i & valid_i.
- Latency: inputs appear on outputs one cycle after load. Forwarding muxes and output selection are combinational from the registered state plus the current-cycle exmem/memwb inputs.
- alu_ctrl decode, registered at load:
  - alu_op 000 (addi/lw/sw) -> 0010.
  - alu_op 001 (beq/bne) -> 0110.
  - alu_op 011 (ori) -> 0001.
  - alu_op 100 (lui) -> 1011.
  - alu_op 101 (sltiu) -> 0111.
  - alu_op 010 (R-type), by funct:
    - 0x21 addu -> 0010.
    - 0x23 subu -> 0110.
    - 0x24 and -> 0000.
    - 0x25 or -> 0001.
    - 0x2A slt -> 1000.
    - 0x2B sltu -> 0111.
    - 0x03 sra -> 1001.
    - 0x07 srav -> 1001.
  - Any other combination -> 0000, and the stored reg_write is forced to 0.
- Forwarding, separately for rs and rt:
  - If exmem_wen_i && exmem_rd_i == idx && idx != 0, use exmem_data_i.
  - Else if memwb_wen_i && memwb_rd_i == idx && idx != 0, use memwb_data_i.
  - Otherwise use the registered register-file value.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Operand select:
  - sra: src1 = fwd_rt, src2 = zero-extended shamt.
  - srav: src1 = fwd_rt, src2 = fwd_rs.
  - alu_src = 1: src1 = fwd_rs, src2 = extended imm16 (zext selects zero- vs sign-extension).
  - Otherwise: src1 = fwd_rs, src2 = fwd_rt.
- rt_fwd_o = fwd_rt always.
- wr_reg_o = reg_dst ? rd : rt.
- During stall, outputs re-evaluate forwarding each cycle so newly arriving writebacks are picked up.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding as above.
- Undefined: forwarding muxes are removed, operands come only from the registered register-file values, and the exmem_*/memwb_* inputs are ignored. Software or the hazard unit must stall to cover RAW hazards.

Decomposition:
- cpu_pkg holds:
  - ALU control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLTU, ALU_SLT, ALU_SRA, ALU_LUI).
  - alu_op encodings.
  - FUNCT_* constants.
- One combinational sub-module, alu_ctrl_decode (alu_op, funct -> ctrl, legal). It is reused by the single-cycle CPU.

Test Plan:
- Reset: hold rst_i = 0 for 2 cycles with valid_i = 1 -> valid_o = 0, reg_write_o = 0, alu_ctrl_o = 0000, alu_src1_o = alu_src2_o = 0.
- addi, imm16 = 16'hFFFF, zext = 0, rs_data = 5 -> next cycle src1 = 5, src2 = 32'hFFFFFFFF, ctrl = 0010. Same with ori (zext = 1) -> src2 = 32'h0000FFFF, ctrl = 0001.
- sra, rt_data = 32'h80000000, shamt = 4 -> src1 = 32'h80000000, src2 = 4, ctrl = 1001. srav, rs_data = 7 -> src2 = 7.
- Forwarding, rs = rt = 3:
  - exmem_wen = 1, exmem_rd = 3, data = 32'hAAAA -> both operands 32'hAAAA.
  - Add memwb_rd = 3, data = 32'hBBBB -> still 32'hAAAA (EX/MEM priority).
  - rs = 0 with exmem_rd = 0 -> no forwarding.
- stall_i = 1 for 3 cycles while inputs change -> outputs hold. stall_i = 1 with flush_i = 1 -> bubble: valid_o = 0, reg_write_o = 0.
- Illegal funct 0x3F with alu_op = 010, reg_write_i = 1 -> ctrl = 0000, reg_write_o = 0.
